// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the program counter, captures the memory word
// returned for it, and buffers {pc, inst} pairs for decode behind valid/ready.
module fetch_queue #(
  parameter int                  ADDRSIZE = 12,
  parameter int                  WIDTH    = 32,
  parameter int                  DEPTH    = 4,
  parameter logic [ADDRSIZE-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_,
  output logic [ADDRSIZE-1:0]        pc,
  input  logic [WIDTH-1:0]           ir,
  input  logic                       fetch_en,
  input  logic                       redirect,
  input  logic [ADDRSIZE-1:0]        redirect_pc,
  output logic                       if_valid,
  input  logic                       if_ready,
  output logic [WIDTH-1:0]           if_inst,
  output logic [ADDRSIZE-1:0]        if_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [ADDRSIZE-1:0] fetch_pc_reg;
  logic [PTRW-1:0]     wr_ptr_reg;
  logic [PTRW-1:0]     rd_ptr_reg;
  logic [CNTW-1:0]     count_reg;

  logic [ADDRSIZE-1:0] pc_mem   [DEPTH];
  logic [WIDTH-1:0]    inst_mem [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_reg == CNTW'(DEPTH));
  assign empty = (count_reg == '0);

  // Redirect squashes both sides of the handshake in its cycle.
  assign push = fetch_en & ~redirect & ~full;
  assign pop  = ~empty & if_ready & ~redirect;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      fetch_pc_reg <= RESET_PC;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else if (redirect) begin
      fetch_pc_reg <= redirect_pc;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      if (push) begin
        fetch_pc_reg <= fetch_pc_reg + ADDRSIZE'(1);
        wr_ptr_reg   <= wr_ptr_reg + PTRW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTRW'(1);
      end
      count_reg <= count_reg + CNTW'(push) - CNTW'(pop);
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= fetch_pc_reg;
      inst_mem[wr_ptr_reg] <= ir;
    end
  end

  assign pc       = fetch_pc_reg;
  assign count    = count_reg;
  assign if_valid = ~empty;
  assign if_inst  = empty ? '0 : inst_mem[rd_ptr_reg];
  assign if_pc    = empty ? '0 : pc_mem[rd_ptr_reg];

endmodule
